// File: rtl/i2s_slave_rx.sv
// Slave-side I2S receiver: synchronises SCK/WS/SD into ck, tracks frame position, delivers stereo words.
// Optional frame-length checking with frame_err output is enabled by defining I2S_FRAME_CHECK_EN.
`timescale 1ns/1ps
module i2s_slave_rx #(
    parameter int unsigned BITS = 24,
    parameter int unsigned SLOT = 32
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic            sck,
    input  logic            ws,
    input  logic            sd,
    output logic [BITS-1:0] left,
    output logic [BITS-1:0] right,
    output logic            valid,
    output logic [5:0]      frame_posn,
`ifdef I2S_FRAME_CHECK_EN
    output logic            frame_err,
`endif
    output logic            locked
);

    typedef enum logic [1:0] {ST_HUNT, ST_LEFT, ST_RIGHT} state_t;

    localparam logic [5:0] BITS_C = 6'(BITS);
    localparam logic [5:0] SLOT_C = 6'(SLOT);
    localparam logic [5:0] LAST_C = 6'(2 * SLOT - 1);

    logic [1:0]      sck_sync, ws_sync, sd_sync;
    logic            sck_prev, ws_last, ws_ok;
    logic            rise, ws_s, sd_s, ws_fall, ws_rise;
    state_t          state, state_next;
    logic [5:0]      bit_cnt;
    logic [BITS-1:0] shift_l, shift_r, shift_l_n, shift_r_n;
    logic            deliver, frame_bad, enter_left, enter_right;

    assign ws_s    = ws_sync[1];
    assign sd_s    = sd_sync[1];
    assign rise    = sck_sync[1] & ~sck_prev;
    // ws_ok masks the first rise after reset so a ws level present at release is not seen as a change
    assign ws_fall = rise & ws_ok & ws_last & ~ws_s;
    assign ws_rise = rise & ws_ok & ~ws_last & ws_s;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
            ws_last  <= 1'b0;
            ws_ok    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            ws_sync  <= {ws_sync[0], ws};
            sd_sync  <= {sd_sync[0], sd};
            sck_prev <= sck_sync[1];
            if (rise) begin
                ws_last <= ws_s;
                ws_ok   <= 1'b1;
            end
        end
    end

`ifdef I2S_FRAME_CHECK_EN
    localparam logic [6:0] FRAME_LAST = 7'(2 * SLOT - 1);
    logic [6:0] frm_cnt;

    assign frame_bad = (frm_cnt != FRAME_LAST);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= (state == ST_RIGHT) && ws_fall && frame_bad;
            if (rise) begin
                if (ws_fall)
                    frm_cnt <= '0;
                else if (frm_cnt != '1)
                    frm_cnt <= frm_cnt + 7'd1;
            end
        end
    end
`else
    assign frame_bad = 1'b0;
`endif

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            state <= ST_HUNT;
        else
            state <= state_next;
    end

    // The bit on the ws-change rise is the LSB of the slot being closed, so it is shifted before switching
    always_comb begin
        state_next = state;
        shift_l_n  = shift_l;
        shift_r_n  = shift_r;
        deliver    = 1'b0;
        case (state)
            ST_HUNT: begin
                if (ws_fall)
                    state_next = ST_LEFT;
            end
            ST_LEFT: begin
                if (rise && bit_cnt < BITS_C)
                    for (int unsigned i = 0; i < BITS; i++)
                        if (32'(bit_cnt) == BITS - 1 - i)
                            shift_l_n[i] = sd_s;
                if (ws_rise)
                    state_next = ST_RIGHT;
            end
            ST_RIGHT: begin
                if (rise && bit_cnt < BITS_C)
                    for (int unsigned i = 0; i < BITS; i++)
                        if (32'(bit_cnt) == BITS - 1 - i)
                            shift_r_n[i] = sd_s;
                if (ws_fall) begin
                    state_next = ST_LEFT;
                    deliver    = ~frame_bad;
                end
            end
            default: state_next = ST_HUNT;
        endcase
    end

    assign enter_left  = (state_next == ST_LEFT) && (state != ST_LEFT);
    assign enter_right = (state_next == ST_RIGHT) && (state == ST_LEFT);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            left       <= '0;
            right      <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            frame_posn <= '0;
            bit_cnt    <= '0;
            shift_l    <= '0;
            shift_r    <= '0;
        end else begin
            valid <= deliver;
            if (deliver) begin
                left   <= shift_l;
                right  <= shift_r_n;
                locked <= 1'b1;
            end else if (state == ST_RIGHT && ws_fall) begin
                locked <= 1'b0;
            end
            if (rise) begin
                shift_l <= enter_left  ? '0 : shift_l_n;
                shift_r <= enter_right ? '0 : shift_r_n;
                if (enter_left || enter_right)
                    bit_cnt <= '0;
                else if (state != ST_HUNT && bit_cnt < BITS_C)
                    bit_cnt <= bit_cnt + 6'd1;
                if (ws_fall)
                    frame_posn <= '0;
                else if (ws_rise)
                    frame_posn <= SLOT_C;
                else if (frame_posn == LAST_C)
                    frame_posn <= '0;
                else
                    frame_posn <= frame_posn + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: drives I2S frames as a master would and checks recovered words.
`timescale 1ns/1ps
module tb_i2s_slave_rx;

    localparam int BITS = 24;
    localparam int SLOT = 32;

    logic            ck = 1'b0;
    logic            rst_n = 1'b0;
    logic            sck = 1'b0;
    logic            ws = 1'b1;
    logic            sd = 1'b0;
    logic [BITS-1:0] left, right;
    logic            valid, locked;
    logic [5:0]      frame_posn;
`ifdef I2S_FRAME_CHECK_EN
    logic            frame_err;
`endif

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int vwide = 0;
    int ferr_cnt = 0;
    logic [BITS-1:0] last_l = '0;
    logic [BITS-1:0] last_r = '0;
    logic valid_d = 1'b0;

    i2s_slave_rx #(.BITS(BITS), .SLOT(SLOT)) dut (
        .ck(ck),
        .rst_n(rst_n),
        .sck(sck),
        .ws(ws),
        .sd(sd),
        .left(left),
        .right(right),
        .valid(valid),
        .frame_posn(frame_posn),
`ifdef I2S_FRAME_CHECK_EN
        .frame_err(frame_err),
`endif
        .locked(locked)
    );

    always #41.667 ck = ~ck;

    always @(negedge ck) begin
        valid_d <= valid;
        if (rst_n && valid) begin
            vcount <= vcount + 1;
            last_l <= left;
            last_r <= right;
        end
        if (valid && valid_d)
            vwide <= vwide + 1;
`ifdef I2S_FRAME_CHECK_EN
        if (frame_err)
            ferr_cnt <= ferr_cnt + 1;
`endif
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One SCK period: master changes ws/sd with the falling edge, slave samples on the rise
    task automatic send_period(input logic w, input logic d, input int half);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (half) @(negedge ck);
        sck = 1'b1;
        repeat (half) @(negedge ck);
    endtask

    task automatic send_frame(input logic [BITS-1:0] lw, input logic [BITS-1:0] rw,
                              input int ll, input int lr, input int half,
                              input int p_from, input int p_to, input bit chk_posn);
        logic d;
        for (int p = p_from; p <= p_to; p++) begin
            d = 1'b0;
            if (p >= 1 && p <= ll && p <= BITS)
                d = lw[BITS-p];
            else if (p > ll && (p - ll) <= BITS && (p - ll) < lr)
                d = rw[BITS-(p-ll)];
            send_period(p >= ll, d, half);
            if (chk_posn)
                chk("frame_posn", 32'(frame_posn), 32'(p));
        end
    endtask

    task automatic frame(input logic [BITS-1:0] lw, input logic [BITS-1:0] rw,
                         input int half, input bit chk_posn);
        send_frame(lw, rw, SLOT, SLOT, half, 0, 2 * SLOT - 1, chk_posn);
    endtask

    initial begin
        @(negedge ck);
        rst_n = 1'b0;
        repeat (3) @(negedge ck);
        chk("reset_left", 32'(left), 32'h0);
        chk("reset_right", 32'(right), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_posn", 32'(frame_posn), 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);
        rst_n = 1'b1;
        @(negedge ck);

        send_period(1'b1, 1'b0, 6);
        send_period(1'b1, 1'b0, 6);
        frame(24'hA5A5A5, 24'h5A5A5A, 6, 1'b0);
        chk("first_frame_no_valid", 32'(vcount), 32'd0);
        chk("first_frame_unlocked", 32'(locked), 32'd0);
        frame(24'hA5A5A5, 24'h5A5A5A, 6, 1'b1);
        chk("f2_vcount", 32'(vcount), 32'd1);
        chk("f2_left", 32'(last_l), 32'hA5A5A5);
        chk("f2_right", 32'(last_r), 32'h5A5A5A);
        chk("f2_left_hold", 32'(left), 32'hA5A5A5);
        chk("f2_locked", 32'(locked), 32'd1);

        for (int i = 0; i < 4; i++) begin
            frame(24'h123450 + 24'(i), 24'h0ABC00 + 24'(i), 6, 1'b1);
            chk("stream_vcount", 32'(vcount), 32'(2 + i));
            chk("stream_left", 32'(last_l), (i == 0) ? 32'hA5A5A5 : 32'h123450 + 32'(i - 1));
            chk("stream_right", 32'(last_r), (i == 0) ? 32'h5A5A5A : 32'h0ABC00 + 32'(i - 1));
        end
        chk("valid_width", 32'(vwide), 32'd0);

        send_frame(24'hFFFFF0, 24'h123456, 20, 44, 6, 0, 63, 1'b0);
        chk("short_pre_vcount", 32'(vcount), 32'd6);
        chk("short_pre_left", 32'(last_l), 32'h123453);
        frame(24'h0F0F0F, 24'hF0F0F0, 6, 1'b0);
        chk("short_vcount", 32'(vcount), 32'd7);
        chk("short_left", 32'(last_l), 32'hFFFFF0);
        chk("long_right", 32'(last_r), 32'h123456);

        send_frame(24'h111111, 24'h222222, SLOT, SLOT, 6, 0, 40, 1'b1);
        chk("pre_reset_vcount", 32'(vcount), 32'd8);
        rst_n = 1'b0;
        #1;
        chk("midrst_left", 32'(left), 32'h0);
        chk("midrst_right", 32'(right), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_posn", 32'(frame_posn), 32'h0);
        chk("midrst_locked", 32'(locked), 32'h0);
        repeat (3) @(negedge ck);
        rst_n = 1'b1;
        send_frame(24'h111111, 24'h222222, SLOT, SLOT, 6, 41, 63, 1'b0);
        frame(24'h3C3C3C, 24'hC3C3C3, 6, 1'b0);
        chk("after_rst_no_valid", 32'(vcount), 32'd8);
        chk("after_rst_unlocked", 32'(locked), 32'd0);
        frame(24'h777777, 24'h888888, 6, 1'b0);
        chk("relock_vcount", 32'(vcount), 32'd9);
        chk("relock_left", 32'(last_l), 32'h3C3C3C);
        chk("relock_right", 32'(last_r), 32'hC3C3C3);
        chk("relock_locked", 32'(locked), 32'd1);

        frame(24'hAAAAAA, 24'hAAAAAA, 2, 1'b0);
        chk("fast1_vcount", 32'(vcount), 32'd10);
        chk("fast1_left", 32'(last_l), 32'h777777);
        frame(24'h555555, 24'hAAAAAA, 2, 1'b0);
        chk("fast2_vcount", 32'(vcount), 32'd11);
        chk("fast2_left", 32'(last_l), 32'hAAAAAA);
        chk("fast2_right", 32'(last_r), 32'hAAAAAA);
        frame(24'h000000, 24'h000000, 2, 1'b0);
        chk("fast3_vcount", 32'(vcount), 32'd12);
        chk("fast3_left", 32'(last_l), 32'h555555);
        chk("fast3_right", 32'(last_r), 32'hAAAAAA);

`ifdef I2S_FRAME_CHECK_EN
        send_frame(24'h0A0B0C, 24'h0D0E0F, SLOT, SLOT + 2, 6, 0, 2 * SLOT + 1, 1'b0);
        chk("err_pre_vcount", 32'(vcount), 32'd13);
        chk("err_pre_ferr", 32'(ferr_cnt), 32'd0);
        frame(24'h135790, 24'h246800, 6, 1'b0);
        chk("err_suppressed", 32'(vcount), 32'd13);
        chk("err_pulse", 32'(ferr_cnt), 32'd1);
        chk("err_unlocked", 32'(locked), 32'd0);
        frame(24'h000000, 24'h000000, 6, 1'b0);
        chk("err_recover_vcount", 32'(vcount), 32'd14);
        chk("err_recover_left", 32'(last_l), 32'h135790);
        chk("err_recover_right", 32'(last_r), 32'h246800);
        chk("err_recover_locked", 32'(locked), 32'd1);
`endif
        chk("valid_width_end", 32'(vwide), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
